// File: rtl/tcdm_rr_arbiter_pkg.sv
// Shared types for the TCDM round-robin arbiter.
package tcdm_rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/tcdm_rr_arbiter_if.sv
// Master-side and slave-side TCDM buses of the arbiter, bundled in one interface.
interface tcdm_rr_arbiter_if #(
  parameter int NR_MASTERS = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(NR_MASTERS);

  logic [NR_MASTERS-1:0]                 m_req_i;
  logic [NR_MASTERS-1:0][ADDR_WIDTH-1:0] m_add_i;
  logic [NR_MASTERS-1:0]                 m_wen_i;
  logic [NR_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_i;
  logic [NR_MASTERS-1:0][BE_W-1:0]       m_be_i;
  logic [NR_MASTERS-1:0]                 m_gnt_o;
  logic [NR_MASTERS-1:0]                 m_r_valid_o;
  logic [DATA_WIDTH-1:0]                 m_r_rdata_o;
  logic                                  m_r_opc_o;

  logic                                  s_req_o;
  logic [ADDR_WIDTH-1:0]                 s_add_o;
  logic                                  s_wen_o;
  logic [DATA_WIDTH-1:0]                 s_wdata_o;
  logic [BE_W-1:0]                       s_be_o;
  logic                                  s_gnt_i;
  logic                                  s_r_valid_i;
  logic [DATA_WIDTH-1:0]                 s_r_rdata_i;
  logic                                  s_r_opc_i;

  logic [IDX_W-1:0]                      owner_o;

  // Arbiter side
  modport slave (
    input  m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i,
    input  s_gnt_i, s_r_valid_i, s_r_rdata_i, s_r_opc_i,
    output m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o,
    output s_req_o, s_add_o, s_wen_o, s_wdata_o, s_be_o, owner_o
  );

  // Environment side: requesters plus the shared slave port
  modport master (
    output m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i,
    output s_gnt_i, s_r_valid_i, s_r_rdata_i, s_r_opc_i,
    input  m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o,
    input  s_req_o, s_add_o, s_wen_o, s_wdata_o, s_be_o, owner_o
  );
endinterface

// File: rtl/tcdm_rr_arbiter_select.sv
// Combinational find-first requester at or after ptr, wrapping at NR_MASTERS-1.
module tcdm_rr_select #(
  parameter int NR_MASTERS = 4,
  parameter int IDX_W      = $clog2(NR_MASTERS)
) (
  input  logic [NR_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]      ptr,
  output logic [IDX_W-1:0]      idx,
  output logic                  found
);
  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NR_MASTERS - 1; i >= 0; i--) begin
      int j;
      j = (int'(ptr) + i) % NR_MASTERS;
      if (req[j]) begin
        idx   = IDX_W'(j);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin TCDM arbiter with bounded burst-hold and one-cycle response routing.
module tcdm_rr_arbiter
  import tcdm_rr_arbiter_pkg::*;
#(
  parameter int NR_MASTERS = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  tcdm_rr_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NR_MASTERS);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d, owner_q, owner_d, rsp_idx_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pend_q;
  logic [IDX_W-1:0]       rr_idx, sel;
  logic                   rr_found, owner_hold, s_req, hs;
  logic [NR_MASTERS-1:0]  gnt, r_valid;

  tcdm_rr_select #(.NR_MASTERS(NR_MASTERS), .IDX_W(IDX_W)) u_select (
    .req   (bus.m_req_i),
    .ptr   (ptr_q),
    .idx   (rr_idx),
    .found (rr_found)
  );

  assign owner_hold = (state_q == OWNED) && bus.m_req_i[owner_q];
  assign sel        = owner_hold ? owner_q : rr_idx;
  assign s_req      = ~rst_i & (owner_hold | rr_found);
  assign hs         = s_req & bus.s_gnt_i;

  assign bus.s_req_o   = s_req;
  assign bus.s_add_o   = bus.m_add_i[sel];
  assign bus.s_wen_o   = bus.m_wen_i[sel];
  assign bus.s_wdata_o = bus.m_wdata_i[sel];
  assign bus.s_be_o    = bus.m_be_i[sel];
  assign bus.owner_o   = owner_q;

  always_comb begin
    gnt = '0;
    if (hs) gnt[sel] = 1'b1;
  end

  // A response still in flight when reset hits is dropped.
  always_comb begin
    r_valid = '0;
    if (pend_q && bus.s_r_valid_i && !rst_i) r_valid[rsp_idx_q] = 1'b1;
  end

  assign bus.m_gnt_o     = gnt;
  assign bus.m_r_valid_o = r_valid;
  assign bus.m_r_rdata_o = bus.s_r_rdata_i;
  assign bus.m_r_opc_o   = bus.s_r_opc_i;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (hs && owner_hold) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q + CNT_W'(1) == CNT_W'(MAX_BURST)) state_d = IDLE;
    end else if (hs) begin
      // Fresh round-robin grant (also covers an owner that just dropped req).
      ptr_d = (sel == IDX_W'(NR_MASTERS - 1)) ? '0 : sel + IDX_W'(1);
      if (MAX_BURST > 1) begin
        state_d = OWNED;
        owner_d = sel;
        cnt_d   = CNT_W'(1);
      end else begin
        state_d = IDLE;
      end
    end else if (state_q == OWNED && !owner_hold) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      rsp_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      pend_q    <= hs;
      if (hs) rsp_idx_q <= sel;
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge clk_i) $onehot0(bus.m_gnt_o));
  a_rv_onehot:  assert property (@(posedge clk_i) $onehot0(bus.m_r_valid_o));
  a_spurious:   assert property (@(posedge clk_i) disable iff (rst_i)
                                 !(bus.s_r_valid_i && !pend_q));
  a_missing:    assert property (@(posedge clk_i) disable iff (rst_i)
                                 !(pend_q && !bus.s_r_valid_i));
`endif
endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Directed table-driven bench for tcdm_rr_arbiter (4 masters, burst of 2).
module tb_tcdm_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       sgnt;
    logic [3:0] gnt;
    logic [3:0] rv;
    int         owner;
    int         sel;    // expected payload source, -1 when no request
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic prev_hs = 1'b0;

  always #5 clk = ~clk;

  tcdm_rr_arbiter_if #(.NR_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  tcdm_rr_arbiter #(.NR_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic logic [AW-1:0] addr_of(int k);
    return 32'h1000_0000 + (k << 4);
  endfunction
  function automatic logic [DW-1:0] wdata_of(int k);
    return 32'h5A00_0000 + k;
  endfunction
  function automatic logic wen_of(int k);
    return (k % 2) == 0;
  endfunction

  task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    logic [DW-1:0] rd;
    logic          opc;
    @(negedge clk);
    rd  = (id == 18) ? 32'hCAFE_0001 : 32'hDEAD_0000 + id;
    opc = id[0];
    rst              = v.rst;
    bus.m_req_i      = v.req;
    bus.s_gnt_i      = v.sgnt;
    bus.s_r_valid_i  = prev_hs;
    bus.s_r_rdata_i  = rd;
    bus.s_r_opc_i    = opc;
    #1;
    chk("gnt", id, 64'(bus.m_gnt_o), 64'(v.gnt));
    chk("r_valid", id, 64'(bus.m_r_valid_o), 64'(v.rv));
    chk("s_req", id, 64'(bus.s_req_o), 64'(!v.rst && (v.req != 4'b0)));
    chk("owner", id, 64'(bus.owner_o), 64'(v.owner));
    if (v.sel >= 0) begin
      chk("s_add", id, 64'(bus.s_add_o), 64'(addr_of(v.sel)));
      chk("s_wen", id, 64'(bus.s_wen_o), 64'(wen_of(v.sel)));
      chk("s_wdata", id, 64'(bus.s_wdata_o), 64'(wdata_of(v.sel)));
    end
    if (v.rv != 4'b0) begin
      chk("rdata", id, 64'(bus.m_r_rdata_o), 64'(rd));
      chk("opc", id, 64'(bus.m_r_opc_o), 64'(opc));
    end
    prev_hs = !v.rst && v.sgnt && (v.req != 4'b0);
  endtask

  vec_t vt[24];
  vec_t hv[4];

  initial begin
    for (int k = 0; k < N; k++) begin
      bus.m_add_i[k]   = addr_of(k);
      bus.m_wdata_i[k] = wdata_of(k);
      bus.m_wen_i[k]   = wen_of(k);
      bus.m_be_i[k]    = 4'hF;
    end
    bus.m_req_i     = '0;
    bus.s_gnt_i     = 1'b0;
    bus.s_r_valid_i = 1'b0;
    bus.s_r_rdata_i = '0;
    bus.s_r_opc_i   = 1'b0;

    //           rst  req      sgnt gnt      rv       own sel
    vt[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 4'b0000, 0, -1};
    // everyone requesting: 0,0,1,1,2,2,3,3,0
    vt[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0000, 0, 0};
    vt[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0001, 0, 0};
    vt[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0001, 0, 1};
    vt[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0010, 1, 1};
    vt[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 4'b0010, 1, 2};
    vt[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 4'b0100, 2, 2};
    vt[7]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 4'b0100, 2, 3};
    vt[8]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 4'b1000, 3, 3};
    vt[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 4'b1000, 3, 0};
    // owner 0 (cnt 1) drops req, master 3 takes over the same cycle
    vt[10] = '{1'b0, 4'b1000, 1'b1, 4'b1000, 4'b0001, 0, 3};
    vt[11] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b1000, 3, -1};
    // slave stall for 3 cycles with masters 1 and 3 pending
    vt[12] = '{1'b0, 4'b1010, 1'b0, 4'b0000, 4'b0000, 3, 1};
    vt[13] = '{1'b0, 4'b1010, 1'b0, 4'b0000, 4'b0000, 3, 1};
    vt[14] = '{1'b0, 4'b1010, 1'b0, 4'b0000, 4'b0000, 3, 1};
    vt[15] = '{1'b0, 4'b1010, 1'b1, 4'b0010, 4'b0000, 3, 1};
    vt[16] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0010, 1, -1};
    // lone read from master 2, then wrap from ptr 3 to master 0
    vt[17] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1, 2};
    vt[18] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0100, 2, 0};
    vt[19] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0001, 0, -1};
    vt[20] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0000, 0, 1};
    // reset right after a handshake: response dropped, restart at 0
    vt[21] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1, -1};
    vt[22] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0000, 0, 0};
    vt[23] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0001, 0, -1};

    for (int i = 0; i < 24; i++) apply(vt[i], i);

    // Single requester outlasting its burst: re-granted after ownership expires
    hv[0] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000, 0, 2};
    hv[1] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0100, 2, 2};
    hv[2] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0100, 2, 2};
    hv[3] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0100, 2, -1};
    for (int i = 0; i < 4; i++) apply(hv[i], 24 + i);

    @(negedge clk);
    bus.s_r_valid_i = 1'b0;
    bus.m_req_i     = '0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
